backup_sram_ctrl: RTL

//  Bus initiator for the 64K backup RAM (2x 32768x8, 120ns): turns single

---
 rtl/backup_sram_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/backup_sram_ctrl.sv
// Backup SRAM initiator: single word/byte requests -> 2x 32Kx8 strobes.
// Ports: CLK_24M/RESET, REQ/WR/ADDR/BE/WDATA/WP in; BUSY/ACK/RDATA/
// WP_ERR out; SRAM_ADDR, SRAM_DATA (inout), nCE, nOEL/U, nWEL/U to RAMs.
// Optional macro BACKUP_WP_EN: WP=1 at accept blocks the write strobes.
module backup_sram_ctrl #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WR,
  input  logic [14:0] ADDR,
  input  logic [1:0]  BE,
  input  logic [15:0] WDATA,
  input  logic        WP,
  output logic        BUSY,
  output logic        ACK,
  output logic [15:0] RDATA,
  output logic        WP_ERR,
  output logic [14:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DATA,
  output logic        nCE,
  output logic        nOEL,
  output logic        nOEU,
  output logic        nWEL,
  output logic        nWEU
);

  localparam int CW =
    (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RECOVER
  } state_t;

  state_t      state, stateN;
  logic [CW-1:0] cnt, cntN;
  logic        wrQ, wrN;
  logic [1:0]  beQ, beN;
  logic [15:0] wdQ, wdN;
  logic        blkQ, blkN;
  logic        busyN, ackN, wpErrN;
  logic [15:0] rdataN;
  logic [14:0] addrN;
  logic        driveQ, driveN;
  logic        nCEN, nOELN, nOEUN, nWELN, nWEUN;
  logic        blkReq;

  // A blocked write keeps the full timing but never strobes or drives.
`ifdef BACKUP_WP_EN
  assign blkReq = WR & WP;
`else
  logic unusedWp;
  assign unusedWp = WP;
  assign blkReq = 1'b0;
`endif

  assign SRAM_DATA = driveQ ? wdQ : 16'hzzzz;

  always_comb begin
    stateN = state;
    cntN   = cnt;
    wrN    = wrQ;
    beN    = beQ;
    wdN    = wdQ;
    blkN   = blkQ;
    busyN  = BUSY;
    ackN   = 1'b0;
    wpErrN = 1'b0;
    rdataN = RDATA;
    addrN  = SRAM_ADDR;
    driveN = driveQ;
    nCEN   = nCE;
    nOELN  = nOEL;
    nOEUN  = nOEU;
    nWELN  = nWEL;
    nWEUN  = nWEU;
    unique case (state)
      IDLE: begin
        if (REQ) begin
          stateN = SETUP;
          wrN    = WR;
          beN    = BE;
          wdN    = WDATA;
          blkN   = blkReq;
          busyN  = 1'b1;
          addrN  = ADDR;
          nCEN   = 1'b0;
          nOELN  = ~(~WR & BE[0]);
          nOEUN  = ~(~WR & BE[1]);
          driveN = WR & ~blkReq;
        end
      end
      SETUP: begin
        stateN = ACCESS;
        cntN   = CNT_LOAD;
        if (wrQ && !blkQ) begin
          nWELN = ~beQ[0];
          nWEUN = ~beQ[1];
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          stateN = RECOVER;
          nOELN  = 1'b1;
          nOEUN  = 1'b1;
          nWELN  = 1'b1;
          nWEUN  = 1'b1;
          ackN   = 1'b1;
          wpErrN = blkQ;
          // Only enabled lanes update; others keep the previous read.
          if (!wrQ) begin
            if (beQ[0]) rdataN[7:0]  = SRAM_DATA[7:0];
            if (beQ[1]) rdataN[15:8] = SRAM_DATA[15:8];
          end
        end else begin
          cntN = cnt - 1'b1;
        end
      end
      RECOVER: begin
        stateN = IDLE;
        busyN  = 1'b0;
        nCEN   = 1'b1;
        driveN = 1'b0;
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      wrQ       <= 1'b0;
      beQ       <= 2'b00;
      wdQ       <= 16'h0000;
      blkQ      <= 1'b0;
      BUSY      <= 1'b0;
      ACK       <= 1'b0;
      WP_ERR    <= 1'b0;
      RDATA     <= 16'h0000;
      SRAM_ADDR <= 15'h0000;
      driveQ    <= 1'b0;
      nCE       <= 1'b1;
      nOEL      <= 1'b1;
      nOEU      <= 1'b1;
      nWEL      <= 1'b1;
      nWEU      <= 1'b1;
    end else begin
      state     <= stateN;
      cnt       <= cntN;
      wrQ       <= wrN;
      beQ       <= beN;
      wdQ       <= wdN;
      blkQ      <= blkN;
      BUSY      <= busyN;
      ACK       <= ackN;
      WP_ERR    <= wpErrN;
      RDATA     <= rdataN;
      SRAM_ADDR <= addrN;
      driveQ    <= driveN;
      nCE       <= nCEN;
      nOEL      <= nOELN;
      nOEU      <= nOEUN;
      nWEL      <= nWELN;
      nWEU      <= nWEUN;
    end
  end

endmodule
